axilite_req_arbiter: RTL and testbench
======================================

Name: axilite_req_arbiter

Overview:
Round-robin arbiter sharing one AXI-lite master's CPU-side port among NUM_REQ requesters. Accepts one transaction at a time, issues it to the master as a cpu_read/cpu_write request, waits for completion or error, and returns read data and status to the owning requester. Sits between the requester blocks and the master_axilite CPU port. Completion pulses come from the integrating top.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
PARAM_A_W, 32, address width
PARAM_D_W, 8, data width
ID_W, $clog2(NUM_REQ), owner index width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request
req_is_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*PARAM_A_W  flattened addresses, requester i at [i*A_W +: A_W]
req_wdata  in  NUM_REQ*PARAM_D_W  flattened write data
req_ready  out  NUM_REQ  one-hot accept pulse
resp_valid  out  NUM_REQ  one-hot response valid
resp_ready  in  NUM_REQ  per-requester response accept
resp_rdata  out  PARAM_D_W  read data, shared bus
resp_err  out  1  response error flag
owner_id  out  ID_W  index of current owner
m_cpu_read  out  1  to master cpu_read
m_cpu_write  out  1  to master cpu_write
m_cpu_r_addr  out  PARAM_A_W  to master read address
m_cpu_w_addr  out  PARAM_A_W  to master write address
m_cpu_w_data  out  PARAM_D_W  to master write data
m_cpu_stall  out  1  to master cpu_stall
m_axi_ready  in  1  master idle/ack indicator
m_axi_error  in  3  master error vector
m_axi_r_data  in  PARAM_D_W  master read data
m_rd_done  in  1  1-cycle pulse, read response accepted (R_ACK && R_ACK_READY)
m_wr_done  in  1  1-cycle pulse, write response accepted

Behaviour:
- Reset (rst high at posedge): state=IDLE; all outputs 0; latched addr/data/op 0; RR pointer last_grant=NUM_REQ-1 (requester 0 wins first). Reset mid-transaction abandons it; no response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if |req_valid, choose winner = first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ. Same cycle: req_ready[winner]=1 (combinational). Latch winner, op, addr, wdata. Next state ISSUE. Otherwise stay.
- ISSUE: m_cpu_read=~op or m_cpu_write=op from registered state; only the latched op's address/data buses are nonzero. On posedge with m_axi_ready==0 sampled, go to WAIT. With no response the block stays in ISSUE; there is no timeout here.
- WAIT: m_cpu_read/m_cpu_write=0. m_cpu_stall = ~resp_ready[owner] (back-pressures master ACK_READY).
  - On m_rd_done or m_wr_done: capture m_axi_r_data for reads (writes capture 0), set err=0, go to RESP.
  - If |m_axi_error in the same cycle as done or without done: err=1, rdata=0, go to RESP. Error has priority.
- RESP: resp_valid[owner]=1, resp_rdata/resp_err held stable. On resp_ready[owner]: last_grant<=owner, go to IDLE.
- The next arbitration occurs in the cycle after RESP completes, so the minimum turnaround is 1 idle cycle.
- Outside WAIT, m_cpu_stall=0. owner_id holds the last owner when IDLE.
- Never asserts m_cpu_read and m_cpu_write together. At most one req_ready and one resp_valid bit are high at a time.
- A requester dropping req_valid after acceptance has no effect. Requests are not accepted outside IDLE.

Optional Feature:
AXIL_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins. last_grant is unused and does not change.
- Undefined: round-robin as above.

Test Plan:
- Requester 1 reads addr 0x10, slave returns 0xA5 -> req_ready[1] pulse in IDLE; m_cpu_read high until m_axi_ready=0; resp_valid[1] with rdata=0xA5, err=0.
- req_valid=4'b0101 simultaneously after reset -> grant order 0 then 2. Repeated 4'b1111 -> 0,1,2,3,0.
- Requester 3 writes 0x5A to 0x20 -> m_cpu_w_addr=0x20, m_cpu_w_data=0x5A; after m_wr_done, resp_valid[3], rdata=0, err=0.
- Slave withholds ACK until master timeout (m_axi_error=3'b001) -> resp_valid[owner] with err=1, rdata=0.
- resp_ready[owner] low 5 cycles during WAIT -> m_cpu_stall=1 throughout; resp held stable until accepted.
- rst asserted in WAIT -> next cycle all outputs 0, IDLE, requester 0 wins next. With AXIL_ARB_FIXED_PRIO_EN, 4'b1111 held -> requester 0 granted every time.

Source files
------------

// File: rtl/axilite_req_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ requesters onto one AXI-lite master CPU port.
// Define AXIL_ARB_FIXED_PRIO_EN to switch to fixed priority (lowest index wins).
module axilite_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PARAM_A_W = 32,
    parameter int PARAM_D_W = 8,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_is_write,
    input  logic [NUM_REQ*PARAM_A_W-1:0]   req_addr,
    input  logic [NUM_REQ*PARAM_D_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [PARAM_D_W-1:0]           resp_rdata,
    output logic                           resp_err,
    output logic [ID_W-1:0]                owner_id,
    output logic                           m_cpu_read,
    output logic                           m_cpu_write,
    output logic [PARAM_A_W-1:0]           m_cpu_r_addr,
    output logic [PARAM_A_W-1:0]           m_cpu_w_addr,
    output logic [PARAM_D_W-1:0]           m_cpu_w_data,
    output logic                           m_cpu_stall,
    input  logic                           m_axi_ready,
    input  logic [2:0]                     m_axi_error,
    input  logic [PARAM_D_W-1:0]           m_axi_r_data,
    input  logic                           m_rd_done,
    input  logic                           m_wr_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_reg, state_next;
    logic [ID_W-1:0]        owner_reg, owner_next;
    logic                   op_reg, op_next;
    logic [PARAM_A_W-1:0]   addr_reg, addr_next;
    logic [PARAM_D_W-1:0]   wdata_reg, wdata_next;
    logic [PARAM_D_W-1:0]   rdata_reg, rdata_next;
    logic                   err_reg, err_next;
`ifndef AXIL_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]        last_grant_reg, last_grant_next;
`endif

    logic [PARAM_A_W-1:0]   addr_arr  [NUM_REQ];
    logic [PARAM_D_W-1:0]   wdata_arr [NUM_REQ];
    logic                   grant_found;
    logic [ID_W-1:0]        grant_idx;
    logic [ID_W-1:0]        cand_idx;
    int                     cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*PARAM_A_W +: PARAM_A_W];
            assign wdata_arr[gi] = req_wdata[gi*PARAM_D_W +: PARAM_D_W];
        end
    endgenerate

    // Winner search: first requesting index after the last grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(last_grant_reg) + 1 + k) % NUM_REQ;
`endif
            cand_idx = ID_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= '0;
            op_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            last_grant_reg <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            op_reg         <= op_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            last_grant_reg <= last_grant_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        op_next         = op_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        last_grant_next = last_grant_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (grant_found) begin
                    state_next = ST_ISSUE;
                    owner_next = grant_idx;
                    op_next    = req_is_write[grant_idx];
                    addr_next  = addr_arr[grant_idx];
                    wdata_next = wdata_arr[grant_idx];
                end
            end
            ST_ISSUE: begin
                // The master drops its idle flag once it has taken the request.
                if (!m_axi_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (|m_axi_error) begin
                    err_next   = 1'b1;
                    rdata_next = '0;
                    state_next = ST_RESP;
                end else if (m_rd_done || m_wr_done) begin
                    err_next   = 1'b0;
                    rdata_next = op_reg ? '0 : m_axi_r_data;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready[owner_reg]) begin
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    last_grant_next = owner_reg;
`endif
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        resp_valid   = '0;
        m_cpu_read   = 1'b0;
        m_cpu_write  = 1'b0;
        m_cpu_r_addr = '0;
        m_cpu_w_addr = '0;
        m_cpu_w_data = '0;
        m_cpu_stall  = 1'b0;
        if (state_reg == ST_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_reg == ST_RESP) begin
            resp_valid[owner_reg] = 1'b1;
        end
        if (state_reg == ST_ISSUE) begin
            m_cpu_read  = ~op_reg;
            m_cpu_write = op_reg;
            if (op_reg) begin
                m_cpu_w_addr = addr_reg;
                m_cpu_w_data = wdata_reg;
            end else begin
                m_cpu_r_addr = addr_reg;
            end
        end
        // Hold off the master's response handshake until the owner can take it.
        if (state_reg == ST_WAIT) begin
            m_cpu_stall = ~resp_ready[owner_reg];
        end
    end

    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign owner_id   = owner_reg;

endmodule

// File: tb/tb_axilite_req_arbiter.sv
// Directed testbench for axilite_req_arbiter with an inline hand-driven master model.
module tb_axilite_req_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 32;
    localparam int DW  = 8;
    localparam int IW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_is_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [DW-1:0]     resp_rdata;
    logic              resp_err;
    logic [IW-1:0]     owner_id;
    logic              m_cpu_read;
    logic              m_cpu_write;
    logic [AW-1:0]     m_cpu_r_addr;
    logic [AW-1:0]     m_cpu_w_addr;
    logic [DW-1:0]     m_cpu_w_data;
    logic              m_cpu_stall;
    logic              m_axi_ready;
    logic [2:0]        m_axi_error;
    logic [DW-1:0]     m_axi_r_data;
    logic              m_rd_done;
    logic              m_wr_done;

    int n_checks = 0;
    int n_fail   = 0;

    axilite_req_arbiter #(.NUM_REQ(NR), .PARAM_A_W(AW), .PARAM_D_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .owner_id(owner_id),
        .m_cpu_read(m_cpu_read), .m_cpu_write(m_cpu_write),
        .m_cpu_r_addr(m_cpu_r_addr), .m_cpu_w_addr(m_cpu_w_addr),
        .m_cpu_w_data(m_cpu_w_data), .m_cpu_stall(m_cpu_stall),
        .m_axi_ready(m_axi_ready), .m_axi_error(m_axi_error),
        .m_axi_r_data(m_axi_r_data), .m_rd_done(m_rd_done), .m_wr_done(m_wr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Raise req_valid until the arbiter accepts; returns the observed req_ready (0 on timeout).
    task automatic grant(input logic [NR-1:0] v, output logic [NR-1:0] rr);
        rr = '0;
        req_valid = v;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (|req_ready) begin
                rr = req_ready;
                break;
            end
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    // From ISSUE, let the master take the request and finish it. kind: 0 rd_done,
    // 1 wr_done, 2 timeout error only, 3 error together with rd_done. Ends in RESP.
    task automatic to_resp(input int kind, input logic [DW-1:0] data);
        m_axi_ready = 1'b0;
        tick();
        m_axi_r_data = data;
        m_rd_done    = (kind == 0 || kind == 3);
        m_wr_done    = (kind == 1);
        m_axi_error  = (kind == 2) ? 3'b001 : (kind == 3) ? 3'b100 : 3'b000;
        tick();
        m_rd_done   = 1'b0;
        m_wr_done   = 1'b0;
        m_axi_error = 3'b000;
        m_axi_ready = 1'b1;
    endtask

    task automatic accept();
        $display("txn owner=%0d rdata=%02h err=%0b", owner_id, resp_rdata, resp_err);
        resp_ready = '1;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({req_ready, resp_valid, m_cpu_read, m_cpu_write, m_cpu_stall, resp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %0h expected 0",
                     {req_ready, resp_valid, m_cpu_read, m_cpu_write, m_cpu_stall, resp_err});
        end
        n_checks++;
        if ({m_cpu_r_addr, m_cpu_w_addr, m_cpu_w_data, resp_rdata, owner_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got %0h expected 0",
                     {m_cpu_r_addr, m_cpu_w_addr, m_cpu_w_data, resp_rdata, owner_id});
        end
    endtask

    task automatic test_read();
        logic [NR-1:0] rr;
        req_addr[1*AW +: AW] = 32'h0000_0010;
        req_is_write[1] = 1'b0;
        grant(4'b0010, rr);
        n_checks++;
        if (rr !== 4'b0010) begin n_fail++; $display("FAIL rd_grant: got %b expected 0010", rr); end
        n_checks++;
        if ({m_cpu_read, m_cpu_write} !== 2'b10) begin
            n_fail++; $display("FAIL rd_issue_op: got %b expected 10", {m_cpu_read, m_cpu_write});
        end
        n_checks++;
        if (m_cpu_r_addr !== 32'h10 || m_cpu_w_addr !== 32'h0) begin
            n_fail++; $display("FAIL rd_issue_addr: got r=%0h w=%0h expected r=10 w=0", m_cpu_r_addr, m_cpu_w_addr);
        end
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL no_accept_busy: got %b expected 0000", req_ready); end
        req_valid = '0;
        tick();
        tick();
        n_checks++;
        if (m_cpu_read !== 1'b1) begin n_fail++; $display("FAIL rd_issue_hold: got %b expected 1", m_cpu_read); end
        to_resp(0, 8'hA5);
        n_checks++;
        if (resp_valid !== 4'b0010 || resp_rdata !== 8'hA5 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_resp: got v=%b d=%02h e=%b expected v=0010 d=a5 e=0", resp_valid, resp_rdata, resp_err);
        end
        n_checks++;
        if (m_cpu_read !== 1'b0) begin n_fail++; $display("FAIL rd_resp_noread: got %b expected 0", m_cpu_read); end
        accept();
        n_checks++;
        if (resp_valid !== 4'b0000 || owner_id !== 2'd1) begin
            n_fail++; $display("FAIL rd_done_idle: got v=%b own=%0d expected v=0000 own=1", resp_valid, owner_id);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] rr;
        logic [NR-1:0] exp_pair [2];
        logic [NR-1:0] exp_all  [5];
`ifdef AXIL_ARB_FIXED_PRIO_EN
        exp_pair = '{4'b0001, 4'b0001};
        exp_all  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_pair = '{4'b0001, 4'b0100};
        exp_all  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        req_is_write = '0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            grant(4'b0101, rr);
            n_checks++;
            if (rr !== exp_pair[i]) begin n_fail++; $display("FAIL rr_pair%0d: got %b expected %b", i, rr, exp_pair[i]); end
            to_resp(0, 8'h01);
            accept();
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            grant(4'b1111, rr);
            n_checks++;
            if (rr !== exp_all[i]) begin n_fail++; $display("FAIL rr_all%0d: got %b expected %b", i, rr, exp_all[i]); end
            to_resp(0, 8'h02);
            accept();
        end
    endtask

    task automatic test_write();
        logic [NR-1:0] rr;
        req_addr[3*AW +: AW]  = 32'h0000_0020;
        req_wdata[3*DW +: DW] = 8'h5A;
        req_is_write[3] = 1'b1;
        grant(4'b1000, rr);
        n_checks++;
        if (rr !== 4'b1000) begin n_fail++; $display("FAIL wr_grant: got %b expected 1000", rr); end
        n_checks++;
        if ({m_cpu_read, m_cpu_write} !== 2'b01) begin
            n_fail++; $display("FAIL wr_issue_op: got %b expected 01", {m_cpu_read, m_cpu_write});
        end
        n_checks++;
        if (m_cpu_w_addr !== 32'h20 || m_cpu_w_data !== 8'h5A || m_cpu_r_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_issue_bus: got wa=%0h wd=%02h ra=%0h expected wa=20 wd=5a ra=0", m_cpu_w_addr, m_cpu_w_data, m_cpu_r_addr);
        end
        to_resp(1, 8'hFF);
        n_checks++;
        if (resp_valid !== 4'b1000 || resp_rdata !== 8'h00 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_resp: got v=%b d=%02h e=%b expected v=1000 d=00 e=0", resp_valid, resp_rdata, resp_err);
        end
        accept();
        n_checks++;
        if (owner_id !== 2'd3) begin n_fail++; $display("FAIL wr_owner_hold: got %0d expected 3", owner_id); end
        req_is_write[3] = 1'b0;
    endtask

    task automatic test_error();
        logic [NR-1:0] rr;
        req_addr[2*AW +: AW] = 32'h0000_0030;
        grant(4'b0100, rr);
        to_resp(0, 8'h3C);
        n_checks++;
        if (resp_rdata !== 8'h3C || resp_err !== 1'b0) begin
            n_fail++; $display("FAIL err_pre_read: got d=%02h e=%b expected d=3c e=0", resp_rdata, resp_err);
        end
        accept();
        grant(4'b0100, rr);
        to_resp(2, 8'h77);
        n_checks++;
        if (resp_valid !== 4'b0100 || resp_rdata !== 8'h00 || resp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_timeout: got v=%b d=%02h e=%b expected v=0100 d=00 e=1", resp_valid, resp_rdata, resp_err);
        end
        accept();
        grant(4'b0100, rr);
        to_resp(3, 8'hC3);
        n_checks++;
        if (resp_rdata !== 8'h00 || resp_err !== 1'b1) begin
            n_fail++; $display("FAIL err_priority: got d=%02h e=%b expected d=00 e=1", resp_rdata, resp_err);
        end
        accept();
    endtask

    task automatic test_stall();
        logic [NR-1:0] rr;
        grant(4'b0010, rr);
        m_axi_ready = 1'b0;
        tick();
        resp_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (m_cpu_stall !== 1'b1 || m_cpu_read !== 1'b0) begin
                n_fail++; $display("FAIL stall_wait%0d: got s=%b r=%b expected s=1 r=0", i, m_cpu_stall, m_cpu_read);
            end
            tick();
        end
        resp_ready = 4'b0010;
        #1;
        n_checks++;
        if (m_cpu_stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 0", m_cpu_stall); end
        resp_ready   = '0;
        m_axi_r_data = 8'h5C;
        m_rd_done    = 1'b1;
        tick();
        m_rd_done    = 1'b0;
        m_axi_ready  = 1'b1;
        m_axi_r_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (resp_valid !== 4'b0010 || resp_rdata !== 8'h5C || m_cpu_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_resp_hold%0d: got v=%b d=%02h s=%b expected v=0010 d=5c s=0", i, resp_valid, resp_rdata, m_cpu_stall);
            end
            tick();
        end
        accept();
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] rr;
        req_addr[2*AW +: AW] = 32'h0000_0044;
        grant(4'b0100, rr);
        m_axi_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({resp_valid, req_ready, m_cpu_read, m_cpu_write, m_cpu_stall, owner_id} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %0h expected 0",
                     {resp_valid, req_ready, m_cpu_read, m_cpu_write, m_cpu_stall, owner_id});
        end
        rst = 1'b0;
        m_axi_ready = 1'b1;
        grant(4'b1111, rr);
        n_checks++;
        if (rr !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_regrant: got %b expected 0001", rr); end
        to_resp(0, 8'h09);
        accept();
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_is_write = '0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = '0;
        m_axi_ready  = 1'b1;
        m_axi_error  = 3'b000;
        m_axi_r_data = '0;
        m_rd_done    = 1'b0;
        m_wr_done    = 1'b0;
        test_reset();
        test_read();
        test_round_robin();
        test_write();
        test_error();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
